// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: h/v position counters advanced by the pixel strobe, with registered sync,
// blanking, coordinate and line/frame pulse outputs. Define VGA_FRAME_CNT_EN to add an 8-bit frame counter.
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       line_start,
    output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
            $error("vga_sync_gen: H_TOTAL and V_TOTAL must fit in 10-bit counters");
        end
    endgenerate

    logic [9:0] h_q, v_q, h_d, v_d;
    logic [9:0] pix_x_q, pix_y_q;
    logic       hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q;
    logic       h_wrap, v_wrap, vis_d, hs_act_d, vs_act_d;

    // Outputs are decoded from the next position so they line up with the counters on the same edge.
    always_comb begin
        h_wrap   = (h_q == 10'(H_TOTAL - 1));
        v_wrap   = (v_q == 10'(V_TOTAL - 1));
        h_d      = h_wrap ? 10'd0 : h_q + 10'd1;
        v_d      = v_q;
        if (h_wrap) begin
            v_d = v_wrap ? 10'd0 : v_q + 10'd1;
        end
        vis_d    = (h_d < 10'(H_VISIBLE)) && (v_d < 10'(V_VISIBLE));
        hs_act_d = (h_d >= 10'(HS_START)) && (h_d < 10'(HS_END));
        vs_act_d = (v_d >= 10'(VS_START)) && (v_d < 10'(VS_END));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q           <= 10'd0;
            v_q           <= 10'd0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            video_on_q    <= 1'b0;
            pix_x_q       <= 10'd0;
            pix_y_q       <= 10'd0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (pix_en) begin
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hs_act_d ? HS_POL : ~HS_POL;
            vsync_q       <= vs_act_d ? VS_POL : ~VS_POL;
            video_on_q    <= vis_d;
            pix_x_q       <= vis_d ? h_d : 10'd0;
            pix_y_q       <= vis_d ? v_d : 10'd0;
            line_start_q  <= h_wrap;
            frame_start_q <= h_wrap && v_wrap;
        end else begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= 8'd0;
        end else if (pix_en && h_wrap && v_wrap) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a shrunken-timing instance (15 x 8 raster) for table vectors and corner cases,
// plus a default 800 x 525 instance for one full-line check. Frame counter checked when VGA_FRAME_CNT_EN is set.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic reset;
    logic pix_en;

    always #5 clk = ~clk;

    logic       s_hs, s_vs, s_von, s_ls, s_fs;
    logic [9:0] s_px, s_py;
    logic       d_hs, d_vs, d_von, d_ls, d_fs;
    logic [9:0] d_px, d_py;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] s_fcnt, d_fcnt;
`endif

    // Small raster: h 0..14 (visible 0..7, hsync 10..12), v 0..7 (visible 0..3, vsync 5..6)
    vga_sync_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_small (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
        .pix_x(s_px), .pix_y(s_py),
        .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(s_fcnt)
`endif
    );

    vga_sync_gen dut_def (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .hsync(d_hs), .vsync(d_vs), .video_on(d_von),
        .pix_x(d_px), .pix_y(d_py),
        .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(d_fcnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_small(input string nm, input int hs, input int vs, input int von,
                             input int px, input int py, input int ls, input int fs);
        chk({nm, "_hsync"}, int'(s_hs), hs);
        chk({nm, "_vsync"}, int'(s_vs), vs);
        chk({nm, "_video_on"}, int'(s_von), von);
        chk({nm, "_pix_x"}, int'(s_px), px);
        chk({nm, "_pix_y"}, int'(s_py), py);
        chk({nm, "_line_start"}, int'(s_ls), ls);
        chk({nm, "_frame_start"}, int'(s_fs), fs);
    endtask

    // Called at 1 time unit after a rising edge; returns aligned the same way.
    task automatic do_reset();
        reset  = 1'b1;
        pix_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        pix_en = 1'b0;
    endtask

    task automatic strobe_n(input int n);
        if (n > 0) begin
            pix_en = 1'b1;
            repeat (n) @(posedge clk);
            #1;
            pix_en = 1'b0;
        end
    endtask

    typedef struct {
        int k;
        int hs, vs, von, px, py, ls, fs;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int cur;
        int c1, c2, hs_low, von_cnt, ls_cnt;

        // k = strobes since reset; h = k mod 15, v = (k / 15) mod 8
        tbl[0]  = '{k:1,   hs:1, vs:1, von:1, px:1, py:0, ls:0, fs:0};
        tbl[1]  = '{k:7,   hs:1, vs:1, von:1, px:7, py:0, ls:0, fs:0};
        tbl[2]  = '{k:8,   hs:1, vs:1, von:0, px:0, py:0, ls:0, fs:0};
        tbl[3]  = '{k:10,  hs:0, vs:1, von:0, px:0, py:0, ls:0, fs:0};
        tbl[4]  = '{k:12,  hs:0, vs:1, von:0, px:0, py:0, ls:0, fs:0};
        tbl[5]  = '{k:13,  hs:1, vs:1, von:0, px:0, py:0, ls:0, fs:0};
        tbl[6]  = '{k:15,  hs:1, vs:1, von:1, px:0, py:1, ls:1, fs:0};
        tbl[7]  = '{k:18,  hs:1, vs:1, von:1, px:3, py:1, ls:0, fs:0};
        tbl[8]  = '{k:60,  hs:1, vs:1, von:0, px:0, py:0, ls:1, fs:0};
        tbl[9]  = '{k:75,  hs:1, vs:0, von:0, px:0, py:0, ls:1, fs:0};
        tbl[10] = '{k:100, hs:0, vs:0, von:0, px:0, py:0, ls:0, fs:0};
        tbl[11] = '{k:105, hs:1, vs:1, von:0, px:0, py:0, ls:1, fs:0};
        tbl[12] = '{k:119, hs:1, vs:1, von:0, px:0, py:0, ls:0, fs:0};
        tbl[13] = '{k:120, hs:1, vs:1, von:1, px:0, py:0, ls:1, fs:1};
        tbl[14] = '{k:121, hs:1, vs:1, von:1, px:1, py:0, ls:0, fs:0};

        // Reset state, asserted before any clock edge, with pix_en held high
        reset  = 1'b1;
        pix_en = 1'b1;
        #1;
        chk_small("rst_async", 1, 1, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_small("rst_held", 1, 1, 0, 0, 0, 0, 0);
        chk("rst_def_hsync", int'(d_hs), 1);
        chk("rst_def_vsync", int'(d_vs), 1);
        reset  = 1'b0;
        pix_en = 1'b0;

        // Table vectors, pix_en high every clk
        cur = 0;
        for (int i = 0; i < 15; i++) begin
            strobe_n(tbl[i].k - cur);
            cur = tbl[i].k;
            chk_small($sformatf("vec%0d_k%0d", i, tbl[i].k), tbl[i].hs, tbl[i].vs, tbl[i].von,
                      tbl[i].px, tbl[i].py, tbl[i].ls, tbl[i].fs);
        end

        // Freeze mid-line, then resume; line_start drops on an idle clk
        do_reset();
        strobe_n(5);
        repeat (10) @(posedge clk);
        #1;
        chk_small("freeze", 1, 1, 1, 5, 0, 0, 0);
        strobe_n(1);
        chk("resume_pix_x", int'(s_px), 6);
        strobe_n(9);
        chk("wrap_line_start", int'(s_ls), 1);
        @(posedge clk);
        #1;
        chk_small("idle_after_wrap", 1, 1, 1, 0, 1, 0, 0);

        // Async reset mid-frame with both syncs active
        do_reset();
        strobe_n(100);
        chk("pre_areset_hsync", int'(s_hs), 0);
        chk("pre_areset_vsync", int'(s_vs), 0);
        #2;
        pix_en = 1'b1;
        reset  = 1'b1;
        #1;
        chk_small("areset", 1, 1, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_small("areset_pix_en_ignored", 1, 1, 0, 0, 0, 0, 0);
        reset  = 1'b0;
        pix_en = 1'b0;
        strobe_n(1);
        chk_small("after_areset", 1, 1, 1, 1, 0, 0, 0);

        // Strobe every 4th clk: line period, hsync and video_on widths in clk
        do_reset();
        c1 = -1;
        c2 = -1;
        hs_low  = 0;
        von_cnt = 0;
        for (int c = 0; c < 400 && c2 < 0; c++) begin
            pix_en = (c % 4 == 0);
            @(posedge clk);
            #1;
            if (s_ls) begin
                if (c1 < 0) c1 = c;
                else c2 = c;
            end
            if (c1 >= 0 && c2 < 0) begin
                if (!s_hs) hs_low++;
                if (s_von) von_cnt++;
            end
        end
        pix_en = 1'b0;
        chk("div4_first_line_start_clk", c1, 56);
        chk("div4_line_period", (c2 < 0) ? -1 : c2 - c1, 60);
        chk("div4_hsync_low_clks", hs_low, 12);
        chk("div4_video_on_clks", von_cnt, 32);

        // Default timing: one full 800-pixel line
        do_reset();
        hs_low  = 0;
        von_cnt = 0;
        ls_cnt  = 0;
        pix_en  = 1'b1;
        for (int c = 0; c < 800; c++) begin
            @(posedge clk);
            #1;
            if (!d_hs) hs_low++;
            if (d_von) von_cnt++;
            if (d_ls) ls_cnt++;
        end
        pix_en = 1'b0;
        chk("def_hsync_low_strobes", hs_low, 96);
        chk("def_video_on_strobes", von_cnt, 640);
        chk("def_line_starts", ls_cnt, 1);
        chk("def_wrap_line_start", int'(d_ls), 1);
        chk("def_wrap_pix_y", int'(d_py), 1);

`ifdef VGA_FRAME_CNT_EN
        // 257 frames of the small raster wraps the counter to 1
        do_reset();
        chk("fcnt_reset", int'(s_fcnt), 0);
        strobe_n(120);
        chk("fcnt_one_frame", int'(s_fcnt), 1);
        strobe_n(256 * 120);
        chk("fcnt_257_frames", int'(s_fcnt), 1);
        chk("fcnt_frame_start", int'(s_fs), 1);
        chk("fcnt_def_no_frame", int'(d_fcnt), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
